// File: rtl/neosd_pkg.sv
// Shared SD command-line definitions: response modes, frame lengths and CRC7 polynomial.
package neosd_pkg;

  typedef enum logic [1:0] {
    RESP_NONE  = 2'd0,
    RESP_SHORT = 2'd1,
    RESP_LONG  = 2'd2,
    RESP_RSVD  = 2'd3
  } resp_mode_e;

  localparam int         CMD_FRAME_BITS = 48;
  localparam int         RESP_LONG_BITS = 136;
  localparam logic [6:0] CRC7_POLY      = 7'h09;  // x^7 + x^3 + 1

endpackage

// File: rtl/neosd_crc7.sv
// Serial CRC7 (x^7+x^3+1), MSB-first; one bit per enable, synchronous clear.
module neosd_crc7
  import neosd_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic fb;
  assign fb = din ^ crc[6];

  always_ff @(posedge clk) begin
    if (!rstn || clr)
      crc <= '0;
    else if (en)
      crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  end

endmodule

// File: rtl/neosd_card_cmd.sv
// Card-side SD CMD responder: receives 48-bit host commands, hands them to card
// logic over valid/ack, then serialises the short or long response.
module neosd_card_cmd
  import neosd_pkg::*;
#(
  parameter int NCR = 2
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         sd_clk_en_i,
  input  logic         sd_cmd_i,
  output logic         sd_cmd_o,
  output logic         sd_cmd_oe,
  output logic         cmd_valid_o,
  output logic [5:0]   cmd_idx_o,
  output logic [31:0]  cmd_arg_o,
  input  logic         cmd_ack_i,
  input  logic [1:0]   resp_mode_i,
  input  logic [5:0]   resp_idx_i,
  input  logic [31:0]  resp_arg_i,
  input  logic         resp_crc_en_i,
  input  logic [127:0] resp_long_i,
  output logic         err_o
);

  typedef enum logic [1:0] {S_IDLE, S_RX, S_WAIT_ACK, S_TX} state_e;

  state_e         state;
  logic [7:0]     bit_cnt;
  logic [46:0]    rx_sr;
  logic [6:0]     gap_cnt;
  logic           acked;
  logic           tx_crc_sub;
  logic [7:0]     tx_len;
  logic [135:0]   tx_sr;

  logic [6:0]     crc_rx, crc_tx;
  logic [47:0]    frame;
  logic           frame_ok;
  logic           ack_take;
  logic           tx_go;
  logic           tx_done;
  logic           next_bit;
  logic [2:0]     crc_idx;
  logic           unused_bits;

  // frame as it will look once the current (end) bit is shifted in
  assign frame       = {rx_sr, sd_cmd_i};
  assign frame_ok    = frame[46] && frame[0] && (frame[7:1] == crc_rx);
  assign ack_take    = cmd_ack_i && cmd_valid_o;
  assign unused_bits = resp_long_i[0] ^ frame[47];

  assign tx_go   = sd_clk_en_i &&
                   ((state == S_WAIT_ACK && acked && gap_cnt >= 7'(NCR)) ||
                    (state == S_TX && bit_cnt != tx_len));
  assign tx_done = sd_clk_en_i && state == S_TX && bit_cnt == tx_len;

  // bits 40..46 of a short response come from the running TX CRC, not tx_sr
  always_comb begin
    crc_idx  = 3'(8'd46 - bit_cnt);
    next_bit = tx_sr[135];
    if (tx_crc_sub && bit_cnt >= 8'd40 && bit_cnt <= 8'd46)
      next_bit = crc_tx[crc_idx];
  end

  neosd_crc7 u_crc_rx (
    .clk  (clk_i),
    .rstn (rstn_i),
    .clr  (state == S_IDLE),
    .en   (state == S_RX && sd_clk_en_i && bit_cnt < 8'(CMD_FRAME_BITS - 8)),
    .din  (sd_cmd_i),
    .crc  (crc_rx)
  );

  neosd_crc7 u_crc_tx (
    .clk  (clk_i),
    .rstn (rstn_i),
    .clr  (ack_take),
    .en   (tx_go && bit_cnt < 8'(CMD_FRAME_BITS - 8)),
    .din  (next_bit),
    .crc  (crc_tx)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      rx_sr       <= '0;
      gap_cnt     <= '0;
      acked       <= 1'b0;
      tx_crc_sub  <= 1'b0;
      tx_len      <= '0;
      tx_sr       <= '0;
      sd_cmd_o    <= 1'b1;
      sd_cmd_oe   <= 1'b0;
      cmd_valid_o <= 1'b0;
      cmd_idx_o   <= '0;
      cmd_arg_o   <= '0;
      err_o       <= 1'b0;
    end else begin
      err_o <= 1'b0;
      if (ack_take) cmd_valid_o <= 1'b0;

      case (state)
        S_IDLE: begin
          if (sd_clk_en_i && !sd_cmd_i) begin
            state   <= S_RX;
            bit_cnt <= 8'd1;
            rx_sr   <= '0;
          end
        end

        S_RX: begin
          if (sd_clk_en_i) begin
            rx_sr   <= frame[46:0];
            bit_cnt <= bit_cnt + 8'd1;
            if (bit_cnt == 8'(CMD_FRAME_BITS - 1)) begin
              if (frame_ok) begin
                state       <= S_WAIT_ACK;
                cmd_valid_o <= 1'b1;
                cmd_idx_o   <= frame[45:40];
                cmd_arg_o   <= frame[39:8];
                gap_cnt     <= 7'd1;
                acked       <= 1'b0;
              end else begin
                state <= S_IDLE;
                err_o <= 1'b1;
              end
            end
          end
        end

        S_WAIT_ACK: begin
          if (sd_clk_en_i && gap_cnt < 7'(NCR))
            gap_cnt <= gap_cnt + 7'd1;
          if (ack_take) begin
            bit_cnt <= '0;
            case (resp_mode_e'(resp_mode_i))
              RESP_SHORT: begin
                acked      <= 1'b1;
                tx_len     <= 8'(CMD_FRAME_BITS);
                tx_crc_sub <= resp_crc_en_i;
                tx_sr      <= {2'b00, resp_idx_i, resp_arg_i, 7'h7F, 1'b1, 88'd0};
              end
              RESP_LONG: begin
                acked      <= 1'b1;
                tx_len     <= 8'(RESP_LONG_BITS);
                tx_crc_sub <= 1'b0;
                tx_sr      <= {2'b00, 6'b111111, resp_long_i[127:1], 1'b1};
              end
              default: state <= S_IDLE;
            endcase
          end
        end

        S_TX: begin
          if (tx_done) begin
            state     <= S_IDLE;
            sd_cmd_oe <= 1'b0;
            sd_cmd_o  <= 1'b1;
            acked     <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase

      if (tx_go) begin
        state     <= S_TX;
        sd_cmd_o  <= next_bit;
        sd_cmd_oe <= 1'b1;
        tx_sr     <= {tx_sr[134:0], 1'b0};
        bit_cnt   <= bit_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_neosd_card_cmd.sv
// Directed bench for neosd_card_cmd: drives host frames on strobes and checks
// decode, error pulses, response bitstreams, NCR gap and mid-TX reset.
module tb_neosd_card_cmd;

  logic         clk = 1'b0;
  logic         rstn_i, sd_clk_en_i, sd_cmd_i;
  logic         sd_cmd_o, sd_cmd_oe, cmd_valid_o, err_o;
  logic [5:0]   cmd_idx_o;
  logic [31:0]  cmd_arg_o;
  logic         cmd_ack_i, resp_crc_en_i;
  logic [1:0]   resp_mode_i;
  logic [5:0]   resp_idx_i;
  logic [31:0]  resp_arg_i;
  logic [127:0] resp_long_i;

  int n_cmp = 0;
  int n_bad = 0;

  // bench-side observation
  int           scnt = 0;
  logic         sdone = 1'b0;
  logic         oe_q = 1'b0, valid_q = 1'b0;
  int           valid_rises = 0, err_cycles = 0, oe_clk = 0, oe_run = 0, start_s = 0;
  logic [135:0] cap = '0;
  int           end_s = 0, ack_s = 0;

  neosd_card_cmd #(.NCR(2)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn_i),
    .sd_clk_en_i   (sd_clk_en_i),
    .sd_cmd_i      (sd_cmd_i),
    .sd_cmd_o      (sd_cmd_o),
    .sd_cmd_oe     (sd_cmd_oe),
    .cmd_valid_o   (cmd_valid_o),
    .cmd_idx_o     (cmd_idx_o),
    .cmd_arg_o     (cmd_arg_o),
    .cmd_ack_i     (cmd_ack_i),
    .resp_mode_i   (resp_mode_i),
    .resp_idx_i    (resp_idx_i),
    .resp_arg_i    (resp_arg_i),
    .resp_crc_en_i (resp_crc_en_i),
    .resp_long_i   (resp_long_i),
    .err_o         (err_o)
  );

  initial forever #5 clk = ~clk;

  // one strobe every 4 clocks
  initial begin
    sd_clk_en_i = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      sd_clk_en_i = 1'b1;
      @(negedge clk);
      sd_clk_en_i = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (sd_clk_en_i) scnt <= scnt + 1;
    sdone <= sd_clk_en_i;
  end

  always @(negedge clk) begin
    valid_q <= cmd_valid_o;
    if (cmd_valid_o && !valid_q) valid_rises <= valid_rises + 1;
    if (err_o) err_cycles <= err_cycles + 1;
    if (sd_cmd_oe) oe_clk <= oe_clk + 1;
    if (sdone) begin
      oe_q <= sd_cmd_oe;
      if (sd_cmd_oe) begin
        if (!oe_q) begin
          start_s <= scnt;
          oe_run  <= 1;
          cap     <= {135'd0, sd_cmd_o};
        end else begin
          oe_run  <= oe_run + 1;
          cap     <= {cap[134:0], sd_cmd_o};
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      sd_cmd_i = f[i];
      do @(posedge clk); while (!sd_clk_en_i);
      #1;
    end
    end_s    = scnt;
    sd_cmd_i = 1'b1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!cmd_valid_o && n < 400) begin @(negedge clk); n++; end
    if (!cmd_valid_o) chk("valid_tmo", 0, 1);
  endtask

  task automatic do_ack(input logic [1:0] mode, input logic [5:0] idx, input logic [31:0] arg,
                        input logic crc_en, input logic [127:0] lng);
    @(negedge clk);
    resp_mode_i   = mode;
    resp_idx_i    = idx;
    resp_arg_i    = arg;
    resp_crc_en_i = crc_en;
    resp_long_i   = lng;
    cmd_ack_i     = 1'b1;
    @(posedge clk); #1;
    ack_s     = scnt;
    cmd_ack_i = 1'b0;
    chk("valid_fall", cmd_valid_o, 0);
  endtask

  task automatic wait_tx();
    int n = 0;
    while (!sd_cmd_oe && n < 3000) begin @(negedge clk); n++; end
    while (sd_cmd_oe && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) chk("tx_tmo", 0, 1);
  endtask

  logic [127:0] lp;
  logic [135:0] exp_long;
  int b_oe, b_v, b_e, n;

  initial begin
    rstn_i = 1'b0; sd_cmd_i = 1'b1; cmd_ack_i = 1'b0;
    resp_mode_i = '0; resp_idx_i = '0; resp_arg_i = '0; resp_crc_en_i = 1'b0; resp_long_i = '0;
    repeat (5) @(negedge clk);
    chk("rst_cmd_o", sd_cmd_o, 1);
    chk("rst_oe", sd_cmd_oe, 0);
    chk("rst_valid", cmd_valid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_idx", cmd_idx_o, 0);
    chk("rst_arg", cmd_arg_o, 0);
    rstn_i = 1'b1;
    repeat (8) @(negedge clk);

    // CMD0, no response
    b_oe = oe_clk; b_v = valid_rises;
    send_frame(48'h40_0000_0000_95);
    wait_valid();
    chk("cmd0_idx", cmd_idx_o, 0);
    chk("cmd0_arg", cmd_arg_o, 0);
    do_ack(2'd0, 6'd0, 32'd0, 1'b0, '0);
    repeat (60) @(negedge clk);
    chk("cmd0_valid_cnt", valid_rises - b_v, 1);
    chk("cmd0_no_oe", oe_clk - b_oe, 0);

    // CMD8, short R7 with CRC
    send_frame(48'h48_0000_01AA_87);
    wait_valid();
    chk("cmd8_idx", cmd_idx_o, 8);
    chk("cmd8_arg", cmd_arg_o, 32'h1AA);
    do_ack(2'd1, 6'd8, 32'h1AA, 1'b1, '0);
    wait_tx();
    chk("cmd8_resp", cap[47:0], 48'h08_0000_01AA_13);
    chk("cmd8_oe_len", oe_run, 48);
    chk("cmd8_ncr_gap", start_s - end_s, 2);
    chk("cmd8_line_idle", sd_cmd_o, 1);

    // CMD8 with bad CRC, then a good frame with reserved mode
    b_e = err_cycles; b_v = valid_rises;
    send_frame(48'h48_0000_01AA_86);
    repeat (40) @(negedge clk);
    chk("bad_err_pulse", err_cycles - b_e, 1);
    chk("bad_no_valid", valid_rises - b_v, 0);
    b_oe = oe_clk;
    send_frame(48'h40_0000_0000_95);
    wait_valid();
    chk("recov_idx", cmd_idx_o, 0);
    do_ack(2'd3, 6'd1, 32'h1, 1'b1, '0);
    repeat (60) @(negedge clk);
    chk("rsvd_no_oe", oe_clk - b_oe, 0);

    // CMD2, long R2
    lp = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    exp_long = {8'h3F, lp[127:1], 1'b1};
    send_frame(48'h42_0000_0000_4D);
    wait_valid();
    chk("cmd2_idx", cmd_idx_o, 2);
    do_ack(2'd2, 6'd0, 32'd0, 1'b0, lp);
    wait_tx();
    chk("cmd2_resp", cap, exp_long);
    chk("cmd2_oe_len", oe_run, 136);

    // ACMD41, late ack, R3 without CRC
    send_frame(48'h69_4000_0000_77);
    wait_valid();
    chk("acmd41_idx", cmd_idx_o, 41);
    chk("acmd41_arg", cmd_arg_o, 32'h4000_0000);
    repeat (100) @(negedge clk);
    chk("acmd41_still_valid", cmd_valid_o, 1);
    do_ack(2'd1, 6'h3F, 32'h00FF_8000, 1'b0, '0);
    wait_tx();
    chk("acmd41_resp", cap[47:0], 48'h3F_00FF_8000_FF);
    chk("acmd41_start", start_s - ack_s, 1);

    // reset in the middle of a response
    send_frame(48'h48_0000_01AA_87);
    wait_valid();
    do_ack(2'd1, 6'd8, 32'h1AA, 1'b1, '0);
    n = 0;
    while (!sd_cmd_oe && n < 2000) begin @(negedge clk); n++; end
    @(negedge clk);
    while (oe_run < 20 && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) chk("mid_tmo", 0, 1);
    chk("mid_oe_before", sd_cmd_oe, 1);
    rstn_i = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_oe", sd_cmd_oe, 0);
    chk("mid_rst_cmd_o", sd_cmd_o, 1);
    chk("mid_rst_valid", cmd_valid_o, 0);
    chk("mid_rst_idx", cmd_idx_o, 0);
    @(negedge clk);
    rstn_i = 1'b1;
    repeat (8) @(negedge clk);
    send_frame(48'h48_0000_01AA_87);
    wait_valid();
    chk("post_rst_idx", cmd_idx_o, 8);
    chk("post_rst_arg", cmd_arg_o, 32'h1AA);
    do_ack(2'd0, 6'd0, 32'd0, 1'b0, '0);
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
